// File: rtl/stroke_stepper.sv
// stroke_stepper
//   Moves the pen from its current absolute position to a latched target
//   (mx/my/mz) as a straight 3-axis line using Bresenham interpolation.
//   It emits step/dir pulses for the X/Y/Z stepper drivers, tracks the
//   absolute pen position and returns a fixed-length ack per completed move.
//
//   Parameters
//     STEP_DIV : clk cycles between successive major-axis step events
//     PULSE_W  : clk cycles each step output stays high
//     ACK_LEN  : clk cycles ack stays high per completed move
//
//   Ports
//     clk, rst_n            : clock, asynchronous active-low reset
//     mx, my, mz            : target position, sampled when a move is accepted
//     start                 : move request, accepted on its rising edge in IDLE
//     pause                 : freezes step scheduling while high
//     step_x/y/z, dir_x/y/z : stepper driver outputs (dir 1 = increment)
//     busy                  : high from accept until ack drops
//     ack                   : move complete strobe
//     pos_x, pos_y, pos_z   : current absolute pen position
module stroke_stepper #(
    parameter int unsigned STEP_DIV = 5000,
    parameter int unsigned PULSE_W  = 100,
    parameter int unsigned ACK_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] mx,
    input  logic [9:0]  my,
    input  logic [8:0]  mz,
    input  logic        start,
    input  logic        pause,
    output logic        step_x,
    output logic        step_y,
    output logic        step_z,
    output logic        dir_x,
    output logic        dir_y,
    output logic        dir_z,
    output logic        busy,
    output logic        ack,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic [8:0]  pos_z
);

    localparam int unsigned TW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned PWW = (PULSE_W > 0) ? $clog2(PULSE_W + 1) : 1;
    localparam int unsigned AW  = $clog2(ACK_LEN + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic [PWW-1:0] PW_LOAD   = PWW'(PULSE_W - 1);
    localparam logic [AW-1:0]  ACK_LAST  = AW'(ACK_LEN);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
    state_t state, state_nx;

    logic           start_d;
    logic [10:0]    tx;
    logic [9:0]     ty;
    logic [8:0]     tz;
    logic [11:0]    d_x, d_y, d_z;
    logic [11:0]    acc_x, acc_y, acc_z;
    logic [11:0]    n_r, cnt;
    logic [TW-1:0]  tick;
    logic [PWW-1:0] pw_cnt;
    logic [AW-1:0]  ack_cnt;

    // Setup-stage geometry, evaluated from the latched target and live position
    logic        sdir_x, sdir_y, sdir_z;
    logic [11:0] sd_x, sd_y, sd_z, sn;
    // Step-event arithmetic
    logic        step_evt, pulse_active, run_done;
    logic [12:0] s_x, s_y, s_z, n13;
    logic        hit_x, hit_y, hit_z;
    logic [11:0] an_x, an_y, an_z;

    always_comb begin
        sdir_x = tx > pos_x;
        sdir_y = ty > pos_y;
        sdir_z = tz > pos_z;
        sd_x   = sdir_x ? ({1'b0, tx} - {1'b0, pos_x}) : ({1'b0, pos_x} - {1'b0, tx});
        sd_y   = sdir_y ? ({2'b0, ty} - {2'b0, pos_y}) : ({2'b0, pos_y} - {2'b0, ty});
        sd_z   = sdir_z ? ({3'b0, tz} - {3'b0, pos_z}) : ({3'b0, pos_z} - {3'b0, tz});
        sn     = sd_x;
        if (sd_y > sn) sn = sd_y;
        if (sd_z > sn) sn = sd_z;
    end

    always_comb begin
        pulse_active = step_x | step_y | step_z;
        step_evt     = (state == S_RUN) && !pause && (tick == TICK_LAST) && (cnt != '0);
        // Last pulse is on its falling edge: the move is finished
        run_done     = (cnt == '0) && pulse_active && (pw_cnt == '0);
        n13   = {1'b0, n_r};
        s_x   = {1'b0, acc_x} + {1'b0, d_x};
        s_y   = {1'b0, acc_y} + {1'b0, d_y};
        s_z   = {1'b0, acc_z} + {1'b0, d_z};
        hit_x = s_x >= n13;
        hit_y = s_y >= n13;
        hit_z = s_z >= n13;
        an_x  = hit_x ? 12'(s_x - n13) : 12'(s_x);
        an_y  = hit_y ? 12'(s_y - n13) : 12'(s_y);
        an_z  = hit_z ? 12'(s_z - n13) : 12'(s_z);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && !start_d) state_nx = S_SETUP;
            S_SETUP: state_nx = (sn == '0) ? S_DONE : S_RUN;
            S_RUN:   if (run_done) state_nx = S_DONE;
            S_DONE:  if (ack && ack_cnt == ACK_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d <= 1'b0;
            tx <= '0; ty <= '0; tz <= '0;
            d_x <= '0; d_y <= '0; d_z <= '0;
            acc_x <= '0; acc_y <= '0; acc_z <= '0;
            n_r <= '0; cnt <= '0; tick <= '0; pw_cnt <= '0; ack_cnt <= '0;
            step_x <= 1'b0; step_y <= 1'b0; step_z <= 1'b0;
            dir_x <= 1'b0; dir_y <= 1'b0; dir_z <= 1'b0;
            busy <= 1'b0; ack <= 1'b0;
            pos_x <= '0; pos_y <= '0; pos_z <= '0;
        end else begin
            start_d <= start;
            case (state)
                S_IDLE: begin
                    if (state_nx == S_SETUP) begin
                        tx   <= mx;
                        ty   <= my;
                        tz   <= mz;
                        busy <= 1'b1;
                    end
                end
                S_SETUP: begin
                    dir_x <= sdir_x; dir_y <= sdir_y; dir_z <= sdir_z;
                    d_x <= sd_x; d_y <= sd_y; d_z <= sd_z;
                    n_r <= sn;
                    cnt <= sn;
                    acc_x <= sn >> 1; acc_y <= sn >> 1; acc_z <= sn >> 1;
                    tick <= '0;
                end
                S_RUN: begin
                    if (!pause) tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
                    if (step_evt) begin
                        cnt    <= cnt - 12'd1;
                        acc_x  <= an_x; acc_y <= an_y; acc_z <= an_z;
                        step_x <= hit_x; step_y <= hit_y; step_z <= hit_z;
                        pw_cnt <= PW_LOAD;
                        if (hit_x) pos_x <= dir_x ? pos_x + 11'd1 : pos_x - 11'd1;
                        if (hit_y) pos_y <= dir_y ? pos_y + 10'd1 : pos_y - 10'd1;
                        if (hit_z) pos_z <= dir_z ? pos_z + 9'd1 : pos_z - 9'd1;
                    end else if (pulse_active) begin
                        // Pulse timing ignores pause so a pulse in flight always completes
                        if (pw_cnt == '0) begin
                            step_x <= 1'b0; step_y <= 1'b0; step_z <= 1'b0;
                        end else begin
                            pw_cnt <= pw_cnt - PWW'(1);
                        end
                    end
                    if (run_done) begin
                        ack     <= 1'b1;
                        ack_cnt <= AW'(1);
                    end
                end
                S_DONE: begin
                    // Zero-length moves arrive here with ack still low
                    if (!ack) begin
                        ack     <= 1'b1;
                        ack_cnt <= AW'(1);
                    end else if (ack_cnt == ACK_LAST) begin
                        ack  <= 1'b0;
                        busy <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stroke_stepper.sv
// tb_stroke_stepper
//   Directed bench for stroke_stepper with STEP_DIV=8, PULSE_W=2, ACK_LEN=4.
//   Expected step/ack rise cycles are queued when each move is launched and
//   popped by a negedge monitor as the corresponding outputs rise.
module tb_stroke_stepper;

    localparam int SD = 8;
    localparam int PW = 2;
    localparam int AL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] mx = '0;
    logic [9:0]  my = '0;
    logic [8:0]  mz = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        step_x, step_y, step_z, dir_x, dir_y, dir_z, busy, ack;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [8:0]  pos_z;

    stroke_stepper #(.STEP_DIV(SD), .PULSE_W(PW), .ACK_LEN(AL)) dut (
        .clk(clk), .rst_n(rst_n), .mx(mx), .my(my), .mz(mz),
        .start(start), .pause(pause),
        .step_x(step_x), .step_y(step_y), .step_z(step_z),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
        .busy(busy), .ack(ack),
        .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0=step_x 1=step_y 2=step_z 3=ack
    typedef struct {int kind; int cyc;} ev_t;
    ev_t sb[$];

    bit         mon_en = 1'b0;
    logic [3:0] prev = '0;
    logic [3:0] cur;
    int         rise_cyc [4];

    always @(negedge clk) begin
        cur = {ack, step_z, step_y, step_x};
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                if (cur[k] && !prev[k]) begin
                    rise_cyc[k] = cyc;
                    if (sb.size() == 0) begin
                        check("unexpected_rise_kind", k, -1);
                    end else begin
                        ev_t e;
                        e = sb.pop_front();
                        check("rise_kind", k, e.kind);
                        check("rise_cycle", cyc, e.cyc);
                    end
                end
                if (!cur[k] && prev[k]) begin
                    if (k == 3) check("ack_width", cyc - rise_cyc[k], AL);
                    else        check("step_width", cyc - rise_cyc[k], PW);
                end
            end
        end
        prev = cur;
    end

    int mpx = 0, mpy = 0, mpz = 0;

    task automatic run_move(input int tx, input int ty, input int tz,
                            input bit extra_start, input bit do_pause);
        int  a, dx, dy, dz, n, ax, ay, az, c, shift;
        bit  ex, ey, ez;
        ex = tx > mpx; ey = ty > mpy; ez = tz > mpz;
        dx = ex ? tx - mpx : mpx - tx;
        dy = ey ? ty - mpy : mpy - ty;
        dz = ez ? tz - mpz : mpz - tz;
        n = dx;
        if (dy > n) n = dy;
        if (dz > n) n = dz;
        @(negedge clk);
        mx = 11'(tx); my = 10'(ty); mz = 9'(tz);
        start = 1'b1;
        a = cyc + 1;
        ax = n / 2; ay = n / 2; az = n / 2;
        for (int k = 1; k <= n; k++) begin
            shift = (do_pause && k > 1) ? 20 : 0;
            c = a + 1 + k * SD + shift;
            if (ax + dx >= n) begin sb.push_back('{kind: 0, cyc: c}); ax = ax + dx - n; end else ax = ax + dx;
            if (ay + dy >= n) begin sb.push_back('{kind: 1, cyc: c}); ay = ay + dy - n; end else ay = ay + dy;
            if (az + dz >= n) begin sb.push_back('{kind: 2, cyc: c}); az = az + dz - n; end else az = az + dz;
        end
        if (n == 0) sb.push_back('{kind: 3, cyc: a + 2});
        else        sb.push_back('{kind: 3, cyc: a + 1 + n * SD + PW + (do_pause ? 20 : 0)});
        @(negedge clk);
        check("busy_on_accept", busy, 1);
        start = 1'b0;
        @(negedge clk);
        check("dir_x", dir_x, ex);
        check("dir_y", dir_y, ey);
        check("dir_z", dir_z, ez);
        if (extra_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (do_pause) begin
            for (int i = 0; i < 100 && cyc < a + 1 + SD; i++) @(negedge clk);
            check("pause_align", cyc, a + 1 + SD);
            pause = 1'b1;
            repeat (20) @(posedge clk);
            @(negedge clk);
            pause = 1'b0;
        end
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        check("busy_end", busy, 0);
        check("ack_end", ack, 0);
        check("pos_x", pos_x, tx);
        check("pos_y", pos_y, ty);
        check("pos_z", pos_z, tz);
        check("sb_drained", sb.size(), 0);
        mpx = tx; mpy = ty; mpz = tz;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        bit ack_seen;

        // Reset asserted between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("rst_step", {step_x, step_y, step_z}, 0);
        check("rst_dir", {dir_x, dir_y, dir_z}, 0);
        check("rst_busy_ack", {busy, ack}, 0);
        check("rst_pos", {pos_x, pos_y, pos_z}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_move(3, 0, 0, 1'b0, 1'b0);
        run_move(0, 2, 0, 1'b0, 1'b0);
        run_move(0, 2, 0, 1'b0, 1'b0);
        run_move(4, 0, 2, 1'b1, 1'b1);
        run_move(1, 3, 7, 1'b0, 1'b0);

        // Reset in the middle of a 5-step move
        mon_en = 1'b0;
        @(negedge clk);
        mx = 11'd6; my = 10'd4; mz = 9'd5;
        start = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && cyc < a + 1 + 2 * SD; i++) @(negedge clk);
        check("step2_high", step_x, 1);
        check("pos_mid", pos_x, mpx + 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_step", {step_x, step_y, step_z}, 0);
        check("midrst_pos", {pos_x, pos_y, pos_z}, 0);
        check("midrst_busy_ack", {busy, ack}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack) ack_seen = 1'b1;
        end
        check("no_ack_after_reset", ack_seen, 0);
        check("idle_after_reset", busy, 0);
        sb.delete();
        mpx = 0; mpy = 0; mpz = 0;
        mon_en = 1'b1;
        run_move(2, 1, 5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
